// File: rtl/led_pwm_if.sv
// led_pwm_if: LED colour word in, three PWM drives and a period marker out
interface led_pwm_if;
    logic [23:0] i_led_data;
    logic        o_pwm_r;
    logic        o_pwm_g;
    logic        o_pwm_b;
    logic        o_period_start;
    modport master (output i_led_data, input o_pwm_r, o_pwm_g, o_pwm_b, o_period_start);
    modport slave  (input i_led_data, output o_pwm_r, o_pwm_g, o_pwm_b, o_period_start);
endinterface

// File: rtl/led_pwm.sv
// led_pwm: 255-tick RGB PWM with boundary-only duty updates; LED_PWM_FADE_EN makes duties step by 1 per period
module led_pwm #(
    parameter int unsigned PRESCALE_DIV = 4,
    parameter bit          ACTIVE_HIGH  = 1
) (
    input logic      i_clk,
    input logic      i_reset,
    led_pwm_if.slave bus
);
    localparam logic [15:0] PRE_LAST = 16'(PRESCALE_DIV - 1);
    localparam logic        INV      = ~ACTIVE_HIGH;
    logic [15:0] presc;
    logic [7:0]  cnt, duty_r, duty_g, duty_b, nxt_r, nxt_g, nxt_b;
    logic        init, tick, wrap, bnd;
`ifdef LED_PWM_FADE_EN
    function automatic logic [7:0] step(input logic [7:0] d, input logic [7:0] t);
        return t > d ? d + 8'd1 : t < d ? d - 8'd1 : d;
    endfunction
`endif
    always_comb begin
        tick = presc == PRE_LAST;
        wrap = tick && cnt == 8'd254;
        bnd  = wrap || init;
`ifdef LED_PWM_FADE_EN
        nxt_r = step(duty_r, bus.i_led_data[15:8]);
        nxt_g = step(duty_g, bus.i_led_data[23:16]);
        nxt_b = step(duty_b, bus.i_led_data[7:0]);
`else
        nxt_r = bus.i_led_data[15:8];
        nxt_g = bus.i_led_data[23:16];
        nxt_b = bus.i_led_data[7:0];
`endif
    end
    // the first cycle out of reset acts as a boundary: counters hold at 0 while duties load
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            presc              <= '0;
            cnt                <= '0;
            duty_r             <= '0;
            duty_g             <= '0;
            duty_b             <= '0;
            init               <= 1'b1;
            bus.o_pwm_r        <= INV;
            bus.o_pwm_g        <= INV;
            bus.o_pwm_b        <= INV;
            bus.o_period_start <= 1'b0;
        end else begin
            init  <= 1'b0;
            presc <= init || tick ? '0 : presc + 16'd1;
            cnt   <= init || wrap ? '0 : tick ? cnt + 8'd1 : cnt;
            if (bnd) begin
                duty_r <= nxt_r;
                duty_g <= nxt_g;
                duty_b <= nxt_b;
            end
            bus.o_period_start <= bnd;
            bus.o_pwm_r        <= (cnt < duty_r) ^ INV;
            bus.o_pwm_g        <= (cnt < duty_g) ^ INV;
            bus.o_pwm_b        <= (cnt < duty_b) ^ INV;
        end
    end
endmodule

// File: doc/led_pwm.md
LED_PWM -- requirements
Module: led_pwm

Interface
REQ-001 The module SHALL have parameter PRESCALE_DIV, default 4, giving the number of i_clk cycles per PWM tick; legal range 1..65535.
REQ-002 The module SHALL have parameter ACTIVE_HIGH, default 1; when set to 0, all three PWM outputs are inverted.
REQ-003 i_clk  input  1  single clock; all logic runs on its rising edge.
REQ-004 i_reset  input  1  reset; synchronous and active-high.
REQ-005 i_led_data  input  24  latched LED colour word in GRB order: G[23:16], R[15:8], B[7:0].
REQ-006 o_pwm_r  output  1  registered red PWM drive.
REQ-007 o_pwm_g  output  1  registered green PWM drive.
REQ-008 o_pwm_b  output  1  registered blue PWM drive.
REQ-009 o_period_start  output  1  single-cycle pulse marking the first cycle of each PWM period.

Function
REQ-010 The prescaler counter SHALL count 0..PRESCALE_DIV-1 and wrap; tick is asserted in the cycle the counter equals PRESCALE_DIV-1.
REQ-011 When PRESCALE_DIV=1, tick SHALL be asserted every cycle.
REQ-012 The 8-bit PWM counter SHALL advance by 1 on each tick over the range 0..254, giving a period of 255 ticks; value 255 is never reached.
REQ-013 On a tick with PWM counter = 254, the counter SHALL wrap to 0; that wrap is the period boundary.
REQ-014 At the period boundary, active duties (R, G, B) SHALL be updated from i_led_data as sampled in the same cycle; i_led_data changes at any other time SHALL NOT affect the current period (glitch-free update).
REQ-015 Each output SHALL be registered as (pwm_cnt < active_duty), using the counter value of the previous cycle, giving 1 cycle of latency, then XOR with ~ACTIVE_HIGH.
REQ-016 Duty 0x00 SHALL give an output that is never active.
REQ-017 Duty 0xFF SHALL give an output that is continuously active.
REQ-018 Duty N SHALL give an output that is active for exactly N ticks per 255-tick period.
REQ-019 o_period_start SHALL pulse high for exactly one i_clk cycle, in the cycle the PWM counter holds 0 immediately after a wrap; it also pulses in the first cycle after reset is released.
REQ-020 The three channels SHALL share one prescaler and one PWM counter, so all rising edges are phase-aligned at the period start.

Reset
REQ-021 While i_reset=1 at a clock edge: the prescaler, PWM counter and all active duties SHALL become 0.
REQ-022 While i_reset=1 at a clock edge: o_pwm_r/g/b SHALL become the inactive level (0 when ACTIVE_HIGH=1, 1 otherwise) and o_period_start SHALL become 0.
REQ-023 Reset asserted mid-period SHALL take effect at the next clock edge, regardless of counter state.
REQ-024 After reset deasserts, the first period SHALL begin with duties loaded from i_led_data on the first cycle.

Configuration
REQ-025 Macro LED_PWM_FADE_EN SHALL control the fade feature.
REQ-026 With LED_PWM_FADE_EN defined: at each period boundary, each active duty SHALL move at most 1 step toward its target byte in i_led_data (+1 if below, -1 if above, hold if equal).
REQ-027 With LED_PWM_FADE_EN defined: targets SHALL be re-sampled every boundary, so a mid-fade target change redirects the fade from the current duty.
REQ-028 With LED_PWM_FADE_EN defined: reset SHALL still force duties to 0, so post-reset ramps start from 0.
REQ-029 Without LED_PWM_FADE_EN: duties SHALL jump directly to the target at the boundary (REQ-014), and no fade logic is synthesised.

Verification
REQ-030 PRESCALE_DIV=1, i_led_data=0x00_80_00 held -> o_pwm_r high for 128 of every 255 cycles, G/B constantly 0, o_period_start every 255 cycles.
REQ-031 PRESCALE_DIV=4, i_led_data=0xFF_00_01 -> G continuously high after first period start, R never high, B high for exactly 4 cycles per 1020-cycle period.
REQ-032 PRESCALE_DIV=1, i_led_data changed 0x000010 -> 0x0000F0 at counter=100 -> current period B high 16 cycles, next period B high 240 cycles, no intermediate pulse widths.
REQ-033 i_reset pulsed at counter=50 with duties 0xFFFFFF -> all outputs 0 next cycle, o_period_start pulses the first cycle after release, full-on resumes.
REQ-034 ACTIVE_HIGH=0, i_led_data=0x000000 -> all outputs constantly 1, including during reset.
REQ-035 LED_PWM_FADE_EN defined, PRESCALE_DIV=1, target R 0x00 -> 0x10 -> R duty 1,2,..,16 in successive periods, steady at 16 thereafter; then target 0x08 -> 8 downward steps.
